bcd_updown_counter: RTL and testbench

- Parametrised N-digit BCD counter: the next-generation decade counter for display/timebase use.
- Adds count enable, up/down direction, parallel load with BCD validity check, and optional saturation.
- Exposes per-digit advance enables and a terminal-count flag for cascading further counters or driving display logic.
- Sits between the system timebase tick and the display/timer logic.

---
 rtl/bcd_pkg.sv | 32 +++
 rtl/bcd_digit.sv | 40 ++++
 rtl/bcd_updown_counter.sv | 136 +++++++++++++
 tb/tb_bcd_updown_counter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared BCD digit constants and helper functions for the
//               up/down decade counter.
// Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

   localparam int              BCD_W   = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
   localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

   // A nibble is a legal decimal digit when it does not exceed nine.
   function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
      return (digit <= BCD_MAX);
   endfunction

   // One decade step in the requested direction, wrapping 9<->0.
   function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] digit,
                                                  input logic             up);
      logic [BCD_W-1:0] r;
      if (up) begin
         r = (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
      end else begin
         r = (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : Single BCD decade cell. Loads ld_val when ld is high,
//               otherwise steps one decade when adv is high.
// Revision    : 1.0  initial release
// ============================================================================
module bcd_digit
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             adv,
   input  logic             up,
   input  logic             ld,
   input  logic [BCD_W-1:0] ld_val,
   output logic [BCD_W-1:0] digit,
   output logic             is_max,
   output logic             is_min
);

   logic [BCD_W-1:0] r_digit;

   // Digit register: load has priority over advance; otherwise hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_digit <= BCD_MIN;
      end else if (ld) begin
         r_digit <= ld_val;
      end else if (adv) begin
         r_digit <= bcd_step(r_digit, up);
      end
   end

   assign digit  = r_digit;
   assign is_max = (r_digit == BCD_MAX);
   assign is_min = (r_digit == BCD_MIN);

endmodule
`default_nettype wire

// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_updown_counter
// Description : N-digit BCD up/down counter with enable, validated parallel
//               load, optional saturation, per-digit advance enables and a
//               terminal-count flag for cascading.
//               Optional feature macro: BCD_UPDOWN_COUNTER_MATCH_EN
//               (registered compare of the count against match_val).
// Revision    : 1.0  initial release
// ============================================================================
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b0
)(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    en,
   input  logic                    up,
   input  logic                    load,
   input  logic [BCD_W*DIGITS-1:0] load_val,
   input  logic [BCD_W*DIGITS-1:0] match_val,
   output logic [BCD_W*DIGITS-1:0] q,
   output logic [DIGITS-1:1]       ena,
   output logic                    tc,
   output logic                    load_err,
   output logic                    match
);

   localparam int QW = BCD_W * DIGITS;

   logic [DIGITS-1:0] w_is_max;
   logic [DIGITS-1:0] w_is_min;
   logic [DIGITS-1:0] w_pre_max;
   logic [DIGITS-1:0] w_pre_min;
   logic [DIGITS-1:0] w_digit_ok;
   logic [DIGITS-1:0] w_adv;
   logic              w_all_max;
   logic              w_all_min;
   logic              w_load_ok;
   logic              w_load_acc;
   logic              w_sat_hold;
   logic              w_count;
   logic              w_tc;
   logic              r_load_err;

   // One cell per decade; load validity is judged per nibble here too.
   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_digit
         bcd_digit u_digit (
            .clk     (clk),
            .reset_n (reset_n),
            .adv     (w_adv[k]),
            .up      (up),
            .ld      (w_load_acc),
            .ld_val  (load_val[BCD_W*k +: BCD_W]),
            .digit   (q[BCD_W*k +: BCD_W]),
            .is_max  (w_is_max[k]),
            .is_min  (w_is_min[k])
         );
         assign w_digit_ok[k] = bcd_valid(load_val[BCD_W*k +: BCD_W]);
      end
   endgenerate

   // Prefix AND chains: digit k may move when every lower digit is at its
   // rollover value for the current direction.
   always_comb begin
      w_pre_max    = '0;
      w_pre_min    = '0;
      w_pre_max[0] = 1'b1;
      w_pre_min[0] = 1'b1;
      for (int k = 1; k < DIGITS; k++) begin
         w_pre_max[k] = w_pre_max[k-1] & w_is_max[k-1];
         w_pre_min[k] = w_pre_min[k-1] & w_is_min[k-1];
      end
   end

   assign w_all_max  = &w_is_max;
   assign w_all_min  = &w_is_min;
   assign w_tc       = en & ((up & w_all_max) | (~up & w_all_min));
   assign w_load_ok  = &w_digit_ok;
   assign w_load_acc = load & w_load_ok;
   // In saturating builds the terminal value is sticky in its direction.
   assign w_sat_hold = SATURATE & w_tc;
   // Any load request, accepted or rejected, suppresses counting.
   assign w_count    = en & ~load & ~w_sat_hold;
   assign w_adv      = {DIGITS{w_count}} & (up ? w_pre_max : w_pre_min);

   assign ena      = w_adv[DIGITS-1:1];
   assign tc       = w_tc;
   assign load_err = r_load_err;

   // Rejected-load flag: a single-cycle pulse following the bad load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_load_err <= 1'b0;
      end else begin
         r_load_err <= load & ~w_load_ok;
      end
   end

`ifdef BCD_UPDOWN_COUNTER_MATCH_EN
   logic [QW-1:0] w_q_next;
   logic          r_match;

   // Next-state view of the count, so match lines up with the new q.
   always_comb begin
      w_q_next = q;
      for (int k = 0; k < DIGITS; k++) begin
         if (w_load_acc) begin
            w_q_next[BCD_W*k +: BCD_W] = load_val[BCD_W*k +: BCD_W];
         end else if (w_adv[k]) begin
            w_q_next[BCD_W*k +: BCD_W] = bcd_step(q[BCD_W*k +: BCD_W], up);
         end
      end
   end

   // Compare flag registered alongside the count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_match <= 1'b0;
      end else begin
         r_match <= (w_q_next == match_val);
      end
   end

   assign match = r_match;
`else
   logic w_unused_match_val;
   assign w_unused_match_val = ^match_val;
   assign match              = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_updown_counter
// Description : Scoreboard bench for bcd_updown_counter. A wrapping and a
//               saturating instance share one stimulus stream; an integer
//               reference model predicts each cycle's outputs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_updown_counter;

   localparam int D   = 4;
   localparam int W   = 4 * D;
   localparam int MOD = 10000;

   logic         clk       = 1'b0;
   logic         reset_n   = 1'b0;
   logic         en        = 1'b0;
   logic         up        = 1'b0;
   logic         load      = 1'b0;
   logic [W-1:0] load_val  = '0;
   logic [W-1:0] match_val = 16'h0005;

   logic [W-1:0] q0, q1;
   logic [D-1:1] ena0, ena1;
   logic         tc0, tc1, le0, le1, m0, m1;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [W-1:0] q;
      logic [D-1:1] ena;
      logic         tc;
      logic         le;
      logic         m;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];

   // Reference model state: count as plain integer, plus registered flags.
   int   mv[2];
   logic mle[2];
   logic mm[2];

   bcd_updown_counter #(.DIGITS(D), .SATURATE(1'b0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
      .load_val(load_val), .match_val(match_val), .q(q0), .ena(ena0),
      .tc(tc0), .load_err(le0), .match(m0));

   bcd_updown_counter #(.DIGITS(D), .SATURATE(1'b1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
      .load_val(load_val), .match_val(match_val), .q(q1), .ena(ena1),
      .tc(tc1), .load_err(le1), .match(m1));

   always #5 clk = ~clk;

   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r;
      int           t;
      t = v;
      for (int k = 0; k < D; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int bcd2int(input logic [W-1:0] b);
      int r;
      r = 0;
      for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(b[4*k +: 4]);
      return r;
   endfunction

   function automatic bit bcd_ok(input logic [W-1:0] b);
      bit ok;
      ok = 1'b1;
      for (int k = 0; k < D; k++) if (b[4*k +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   function automatic int pow10(input int k);
      int r;
      r = 1;
      for (int i = 0; i < k; i++) r = r * 10;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Issue one cycle of stimulus, predict what both instances show this
   // cycle, then advance the model to the post-edge state.
   task automatic step(input logic e, input logic u, input logic l, input logic [W-1:0] lv);
      exp_t x;
      int   nv;
      int   p;
      bit   sat, tcx, adv;
      en = e; up = u; load = l; load_val = lv;
      for (int s = 0; s < 2; s++) begin
         sat   = (s == 1);
         tcx   = e && (u ? (mv[s] == MOD - 1) : (mv[s] == 0));
         adv   = e && !l && !(sat && tcx);
         x.q   = int2bcd(mv[s]);
         x.le  = mle[s];
         x.m   = mm[s];
         x.tc  = tcx;
         for (int k = 1; k < D; k++) begin
            p = pow10(k);
            x.ena[k] = adv && (u ? (mv[s] % p == p - 1) : (mv[s] % p == 0));
         end
         nv     = mv[s];
         mle[s] = 1'b0;
         if (l) begin
            if (bcd_ok(lv)) nv = bcd2int(lv);
            else            mle[s] = 1'b1;
         end else if (adv) begin
            nv = u ? (nv + 1) % MOD : (nv + MOD - 1) % MOD;
         end
         mv[s] = nv;
`ifdef BCD_UPDOWN_COUNTER_MATCH_EN
         mm[s] = (int2bcd(nv) == match_val);
`else
         mm[s] = 1'b0;
`endif
         if (s == 0) sb0.push_back(x);
         else        sb1.push_back(x);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int s = 0; s < 2; s++) begin
         mv[s] = 0; mle[s] = 1'b0; mm[s] = 1'b0;
      end
   endtask

   // Reset asserted between edges: outputs must clear without a clock.
   task automatic async_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      en = 1'b0; load = 1'b0;
      #1;
      chk("async_rst_q0", 32'(q0), 32'h0);
      chk("async_rst_q1", 32'(q1), 32'h0);
      chk("async_rst_le0", 32'(le0), 32'h0);
      chk("async_rst_m0", 32'(m0), 32'h0);
      model_clear();
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string nm, input exp_t x, input logic [W-1:0] aq,
                      input logic [D-1:1] aena, input logic atc, input logic ale,
                      input logic am);
      chk({nm, "_q"},        32'(aq),   32'(x.q));
      chk({nm, "_ena"},      32'(aena), 32'(x.ena));
      chk({nm, "_tc"},       32'(atc),  32'(x.tc));
      chk({nm, "_load_err"}, 32'(ale),  32'(x.le));
      chk({nm, "_match"},    32'(am),   32'(x.m));
   endtask

   // Monitor: compare whatever the stimulus side predicted for this cycle.
   always @(negedge clk) begin
      exp_t x;
      if (sb0.size() > 0) begin
         x = sb0.pop_front();
         cmp("wrap", x, q0, ena0, tc0, le0, m0);
      end
      if (sb1.size() > 0) begin
         x = sb1.pop_front();
         cmp("sat", x, q1, ena1, tc1, le1, m1);
      end
   end

   initial begin
      logic [W-1:0] lv;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_q0", 32'(q0), 32'h0);
      chk("reset_q1", 32'(q1), 32'h0);
      chk("reset_le1", 32'(le1), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Full decade sweep upward with wrap (sat instance parks at 9999).
      for (int i = 0; i < MOD + 5; i++) step(1'b1, 1'b1, 1'b0, '0);

      // Borrow across two digits.
      step(1'b0, 1'b1, 1'b1, 16'h0100);
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);

      // Rejected load while enabled: hold, pulse error, then resume.
      step(1'b0, 1'b1, 1'b1, 16'h0057);
      step(1'b1, 1'b1, 1'b1, 16'h12A4);
      step(1'b1, 1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 1'b0, '0);

      // Upper terminal, then reverse.
      step(1'b0, 1'b1, 1'b1, 16'h9998);
      repeat (3) step(1'b1, 1'b1, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);

      // Lower terminal.
      step(1'b0, 1'b0, 1'b1, 16'h0001);
      repeat (3) step(1'b1, 1'b0, 1'b0, '0);

      // Asynchronous reset mid-count at 4321, then resume from zero.
      step(1'b0, 1'b1, 1'b1, 16'h4318);
      repeat (3) step(1'b1, 1'b1, 1'b0, '0);
      @(negedge clk);
      #1;
      chk("pre_rst_q0", 32'(q0), 32'h4321);
      async_reset();
      repeat (10) step(1'b1, 1'b1, 1'b0, '0);

      // Randomised mix of enable, direction and (sometimes bad) loads.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom % 2 == 0) lv = int2bcd(int'($urandom % MOD));
         else                   lv = 16'($urandom);
         step(($urandom % 4) != 0, ($urandom % 2) == 1, ($urandom % 12) == 0, lv);
      end
      step(1'b0, 1'b1, 1'b0, '0);

      @(negedge clk);
      #2;
      checks++;
      if (sb0.size() != 0 || sb1.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", sb0.size() + sb1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
